// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper datapath: cell encodings,
// cover-board FSM states and the 8-neighbour visiting order.
package minesweeper_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_POP  = 2'd2,
        ST_NBR  = 2'd3
    } fsm_state_t;

    localparam logic [1:0] COVERED = 2'b00;
    localparam logic [1:0] OPENED  = 2'b01;
    localparam logic [1:0] FLAGGED = 2'b10;

    // Neighbour order NW, N, NE, W, E, SW, S, SE.
    localparam int NBR_DX [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    localparam int NBR_DY [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

endpackage

// File: rtl/coord_stack.sv
// LIFO of packed {y, x} coordinates used by the flood fill.
// Only the pointer is reset; the storage needs no clearing.
module coord_stack #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty
);
    localparam int ADDR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_BITS  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] ptr_reg;
    logic [PTR_BITS-1:0] top_ptr;
    logic                full;

    assign empty    = (ptr_reg == '0);
    assign full     = (ptr_reg == PTR_BITS'(DEPTH));
    assign top_ptr  = ptr_reg - PTR_BITS'(1);
    assign top_data = mem[top_ptr[ADDR_BITS-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else if (push && !full) begin
            ptr_reg <= ptr_reg + PTR_BITS'(1);
        end else if (pop && !empty) begin
            ptr_reg <= top_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[ptr_reg[ADDR_BITS-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/board_cover_fill.sv
// Cover-state board: tracks covered/opened/flagged per cell, flood-fills
// zero regions via an explicit coordinate stack, and reports counts/win.
module board_cover_fill
    import minesweeper_pkg::*;
#(
    parameter int X_SIZE   = 16,
    parameter int Y_SIZE   = 16,
    parameter int X_BITS   = 4,
    parameter int Y_BITS   = 4,
    parameter int MINES    = 40,
    parameter int CNT_BITS = $clog2(X_SIZE*Y_SIZE+1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flag,
    input  logic                open,
    input  logic [X_BITS-1:0]   x_coord,
    input  logic [Y_BITS-1:0]   y_coord,
    output logic [1:0]          cell_val,
    output logic [X_BITS-1:0]   lk_x,
    output logic [Y_BITS-1:0]   lk_y,
    input  logic                lk_zero,
    input  logic                lk_mine,
    output logic                busy,
    output logic [CNT_BITS-1:0] opened_count,
    output logic [CNT_BITS-1:0] flag_count,
    output logic                mine_hit,
    output logic                all_clear
);
    localparam int CELLS    = X_SIZE * Y_SIZE;
    localparam int IDX_BITS = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int PW       = X_BITS + Y_BITS;
    localparam logic [CNT_BITS-1:0] CLEAR_TARGET = CNT_BITS'(CELLS - MINES);

    function automatic logic [IDX_BITS-1:0] cell_index(input int x, input int y);
        return IDX_BITS'(y * X_SIZE + x);
    endfunction

    fsm_state_t            state_reg, state_next;
    logic [1:0]            cells [CELLS];
    logic [IDX_BITS-1:0]   init_idx_reg;
    logic [X_BITS-1:0]     cur_x_reg;
    logic [Y_BITS-1:0]     cur_y_reg;
    logic [2:0]            nbr_idx_reg;
    logic [CNT_BITS-1:0]   opened_count_reg, flag_count_reg;
    logic                  mine_hit_reg, mine_hit_next;
    logic [1:0]            cell_val_reg;

    logic                  cmd_in_range;
    logic [IDX_BITS-1:0]   cmd_idx;
    logic [1:0]            cmd_cell;
    int                    nx_i, ny_i;
    logic                  nbr_ok;
    logic [X_BITS-1:0]     nbr_x;
    logic [Y_BITS-1:0]     nbr_y;
    logic [IDX_BITS-1:0]   nbr_cell_idx;
    logic [1:0]            nbr_cell;

    logic                  wr_en;
    logic [IDX_BITS-1:0]   wr_idx;
    logic [1:0]            wr_val;
    logic                  push, pop, stack_empty;
    logic [PW-1:0]         push_data, stack_top;
    logic                  open_inc, flag_inc, flag_dec;

    assign cmd_in_range = (int'(x_coord) < X_SIZE) && (int'(y_coord) < Y_SIZE);
    assign cmd_idx      = cell_index(int'(x_coord), int'(y_coord));
    assign cmd_cell     = cells[cmd_idx];

    always_comb begin
        nx_i   = int'(cur_x_reg) + NBR_DX[nbr_idx_reg];
        ny_i   = int'(cur_y_reg) + NBR_DY[nbr_idx_reg];
        nbr_ok = (nx_i >= 0) && (nx_i < X_SIZE) && (ny_i >= 0) && (ny_i < Y_SIZE);
        nbr_x  = nx_i[X_BITS-1:0];
        nbr_y  = ny_i[Y_BITS-1:0];
        nbr_cell_idx = nbr_ok ? cell_index(nx_i, ny_i) : '0;
    end
    assign nbr_cell = cells[nbr_cell_idx];

    assign lk_x = (state_reg == ST_NBR) ? nbr_x : x_coord;
    assign lk_y = (state_reg == ST_NBR) ? nbr_y : y_coord;

    always_comb begin
        state_next    = state_reg;
        wr_en         = 1'b0;
        wr_idx        = cmd_idx;
        wr_val        = COVERED;
        push          = 1'b0;
        push_data     = {y_coord, x_coord};
        pop           = 1'b0;
        open_inc      = 1'b0;
        flag_inc      = 1'b0;
        flag_dec      = 1'b0;
        mine_hit_next = 1'b0;
        case (state_reg)
            ST_INIT: begin
                wr_en  = 1'b1;
                wr_idx = init_idx_reg;
                if (init_idx_reg == IDX_BITS'(CELLS - 1)) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if ((flag ^ open) && cmd_in_range) begin
                    if (flag) begin
                        if (cmd_cell == COVERED) begin
                            wr_en    = 1'b1;
                            wr_val   = FLAGGED;
                            flag_inc = 1'b1;
                        end else if (cmd_cell == FLAGGED) begin
                            wr_en    = 1'b1;
                            wr_val   = COVERED;
                            flag_dec = 1'b1;
                        end
                    end else if (cmd_cell == COVERED) begin
                        wr_en    = 1'b1;
                        wr_val   = OPENED;
                        open_inc = 1'b1;
                        if (lk_mine) begin
                            mine_hit_next = 1'b1;
                        end else if (lk_zero) begin
                            push       = 1'b1;
                            state_next = ST_POP;
                        end
                    end
                end
            end
            ST_POP: begin
                pop        = 1'b1;
                state_next = ST_NBR;
            end
            ST_NBR: begin
                // Opening at push time guarantees each cell enters the stack once.
                if (nbr_ok && nbr_cell == COVERED) begin
                    wr_en     = 1'b1;
                    wr_idx    = nbr_cell_idx;
                    wr_val    = OPENED;
                    open_inc  = 1'b1;
                    push      = lk_zero;
                    push_data = {nbr_y, nbr_x};
                end
                if (nbr_idx_reg == 3'd7) state_next = (push || !stack_empty) ? ST_POP : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    coord_stack #(.DEPTH(CELLS), .WIDTH(PW)) u_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .top_data  (stack_top),
        .empty     (stack_empty)
    );

    always_ff @(posedge clk) begin
        if (wr_en) cells[wr_idx] <= wr_val;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_INIT;
            init_idx_reg     <= '0;
            cur_x_reg        <= '0;
            cur_y_reg        <= '0;
            nbr_idx_reg      <= '0;
            opened_count_reg <= '0;
            flag_count_reg   <= '0;
            mine_hit_reg     <= 1'b0;
            cell_val_reg     <= COVERED;
        end else begin
            state_reg    <= state_next;
            init_idx_reg <= (state_reg == ST_INIT) ? init_idx_reg + IDX_BITS'(1) : '0;
            if (pop) {cur_y_reg, cur_x_reg} <= stack_top;
            nbr_idx_reg  <= pop ? 3'd0 : nbr_idx_reg + 3'd1;
            if (open_inc) opened_count_reg <= opened_count_reg + CNT_BITS'(1);
            if (flag_inc)      flag_count_reg <= flag_count_reg + CNT_BITS'(1);
            else if (flag_dec) flag_count_reg <= flag_count_reg - CNT_BITS'(1);
            mine_hit_reg <= mine_hit_next;
            cell_val_reg <= (state_reg == ST_INIT || !cmd_in_range) ? COVERED : cmd_cell;
        end
    end

    assign cell_val     = cell_val_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign opened_count = opened_count_reg;
    assign flag_count   = flag_count_reg;
    assign mine_hit     = mine_hit_reg;
    assign all_clear    = (opened_count_reg == CLEAR_TARGET);

endmodule
